// File: rtl/kamikaze_imem_if.sv
// ============================================================================
// Module      : kamikaze_imem_if
// Description : Fetch read port and byte-serial loader bundle for kamikaze_imem.
//               The master side is the fetch unit / loader source; the slave
//               side is the instruction memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface kamikaze_imem_if #(
  parameter int ADDR_WIDTH = 10
);
  // fetch read port
  logic [31:0]           im_addr_i;
  logic [31:0]           im_data_o;
  logic                  addr_err_o;
  logic                  parity_err_o;
  // boot loader port
  logic                  ld_start_i;
  logic [ADDR_WIDTH-1:0] ld_base_i;
  logic [ADDR_WIDTH:0]   ld_count_i;
  logic [7:0]            ld_byte_i;
  logic                  ld_valid_i;
  logic                  ld_ready_o;
  logic                  ld_done_o;
  logic                  core_hold_o;

  modport master (
    output im_addr_i, ld_start_i, ld_base_i, ld_count_i, ld_byte_i, ld_valid_i,
    input  im_data_o, addr_err_o, parity_err_o, ld_ready_o, ld_done_o, core_hold_o
  );

  modport slave (
    input  im_addr_i, ld_start_i, ld_base_i, ld_count_i, ld_byte_i, ld_valid_i,
    output im_data_o, addr_err_o, parity_err_o, ld_ready_o, ld_done_o, core_hold_o
  );
endinterface

`default_nettype wire

// File: rtl/kamikaze_imem.sv
// ============================================================================
// Module      : kamikaze_imem
// Description : Synchronous-read instruction memory with a byte-serial boot
//               loader. While a load session runs the core is held and fetch
//               reads return NOP_WORD. Optional feature macro: IMEM_PARITY_EN
//               (adds a stored parity bit per word and read-side checking).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module kamikaze_imem #(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD   = 32'h0000_0013
) (
  input  logic           clk_i,
  input  logic           rst_i,
  kamikaze_imem_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
`ifdef IMEM_PARITY_EN
  localparam int MEM_W = 33;
`else
  localparam int MEM_W = 32;
`endif

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RECV  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [MEM_W-1:0] mem [DEPTH];

  logic [1:0]            state;
  logic [1:0]            state_next;
  logic [ADDR_WIDTH-1:0] base;
  logic [ADDR_WIDTH:0]   count;
  logic [ADDR_WIDTH:0]   n;
  logic [ADDR_WIDTH:0]   n_inc;
  logic [1:0]            lane;
  logic [31:0]           word;
  logic                  hold;
  logic                  byte_fire;

  logic [32:0]           addr_diff;
  logic                  below_base;
  logic                  above_top;
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic [MEM_W-1:0]      rd_word;
  logic                  rd_parity_bad;
  logic [ADDR_WIDTH-1:0] wr_idx;
  logic [MEM_W-1:0]      wr_data;
  logic                  unused_addr_bits;

  // Borrow out of the 33-bit subtract flags addresses below BASE_ADDR.
  assign addr_diff        = {1'b0, bus.im_addr_i} - {1'b0, BASE_ADDR};
  assign below_base       = addr_diff[32];
  assign above_top        = |addr_diff[31:ADDR_WIDTH+2];
  assign rd_idx           = addr_diff[ADDR_WIDTH+1:2];
  assign unused_addr_bits = ^addr_diff[1:0];
  assign rd_word          = mem[rd_idx];

  assign n_inc     = n + {{ADDR_WIDTH{1'b0}}, 1'b1};
  assign byte_fire = (state == S_RECV) && bus.ld_valid_i;
  // Index arithmetic truncates to ADDR_WIDTH bits, giving wrap modulo depth.
  assign wr_idx    = base + n[ADDR_WIDTH-1:0];

`ifdef IMEM_PARITY_EN
  assign wr_data       = {^word, word};
  assign rd_parity_bad = rd_word[32] ^ (^rd_word[31:0]);
`else
  assign wr_data       = word;
  assign rd_parity_bad = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state logic for the load session.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (bus.ld_start_i)
                 state_next = (bus.ld_count_i == '0) ? S_DONE : S_RECV;
      S_RECV:  if (bus.ld_valid_i && (lane == 2'd3)) state_next = S_WRITE;
      S_WRITE: state_next = (n_inc == count) ? S_DONE : S_RECV;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Loader handshake and core hold outputs decoded from the current state.
  always_comb begin
    hold            = (state != S_IDLE);
    bus.ld_ready_o  = (state == S_RECV);
    bus.ld_done_o   = (state == S_DONE);
    bus.core_hold_o = hold;
  end

  // Session bookkeeping: capture base/count, assemble bytes, advance word count.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      base  <= '0;
      count <= '0;
      n     <= '0;
      lane  <= 2'd0;
      word  <= 32'h0;
    end else begin
      if ((state == S_IDLE) && bus.ld_start_i) begin
        base  <= bus.ld_base_i;
        count <= bus.ld_count_i;
        n     <= '0;
        lane  <= 2'd0;
      end
      if (byte_fire) begin
        word[8*lane +: 8] <= bus.ld_byte_i;
        lane              <= lane + 2'd1;
      end
      if (state == S_WRITE) begin
        n    <= n_inc;
        lane <= 2'd0;
      end
    end
  end

  // Memory array write; contents are intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (state == S_WRITE) mem[wr_idx] <= wr_data;
  end

  // Registered fetch read: NOP while held, zero plus error when unmapped.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      bus.im_data_o    <= 32'h0;
      bus.addr_err_o   <= 1'b0;
      bus.parity_err_o <= 1'b0;
    end else if (hold) begin
      bus.im_data_o    <= NOP_WORD;
      bus.addr_err_o   <= 1'b0;
      bus.parity_err_o <= 1'b0;
    end else if (below_base || above_top) begin
      bus.im_data_o    <= 32'h0;
      bus.addr_err_o   <= 1'b1;
      bus.parity_err_o <= 1'b0;
    end else begin
      bus.im_data_o    <= rd_word[31:0];
      bus.addr_err_o   <= 1'b0;
      bus.parity_err_o <= rd_parity_bad;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_kamikaze_imem.sv
// ============================================================================
// Module      : tb_kamikaze_imem
// Description : Directed self-checking bench for kamikaze_imem (depth 16).
//               Expected read results are queued when a read is issued and
//               compared when the registered data appears.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_kamikaze_imem;

  localparam int          AW    = 4;
  localparam int          DEPTH = 16;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  kamikaze_imem_if #(.ADDR_WIDTH(AW)) bus ();

  kamikaze_imem #(
    .ADDR_WIDTH(AW),
    .BASE_ADDR (32'h0000_0000),
    .NOP_WORD  (NOP)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
    logic        perr;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model [DEPTH];
  int          tests = 0;
  int          fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input logic [31:0] a, input logic [31:0] d,
                          input logic e, input logic p);
    exp_t x;
    x.addr = a; x.data = d; x.err = e; x.perr = p;
    exp_q.push_back(x);
  endtask

  // Drive a fetch address; expected result comes from the bench model.
  task automatic issue(input logic [31:0] a, input logic held);
    bus.im_addr_i = a;
    if (held)                 push_exp(a, NOP, 1'b0, 1'b0);
    else if (a >= DEPTH * 4)  push_exp(a, 32'h0, 1'b1, 1'b0);
    else                      push_exp(a, model[a[5:2]], 1'b0, 1'b0);
  endtask

  // Advance one cycle and compare the oldest outstanding read.
  task automatic tick();
    exp_t x;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      chk($sformatf("rd_data@%h", x.addr), bus.im_data_o, x.data);
      chk($sformatf("rd_err@%h", x.addr), {31'b0, bus.addr_err_o}, {31'b0, x.err});
      chk($sformatf("rd_perr@%h", x.addr), {31'b0, bus.parity_err_o}, {31'b0, x.perr});
    end
  endtask

  task automatic start(input logic [AW-1:0] b, input logic [AW:0] c);
    bus.ld_start_i = 1'b1;
    bus.ld_base_i  = b;
    bus.ld_count_i = c;
    @(negedge clk);
    bus.ld_start_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v);
    bus.ld_byte_i  = v;
    bus.ld_valid_i = 1'b1;
    for (int k = 0; k < 50 && !bus.ld_ready_o; k++) @(negedge clk);
    chk("ready_wait", {31'b0, bus.ld_ready_o}, 32'd1);
    @(negedge clk);
    bus.ld_valid_i = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[7:0]);
    send_byte(w[15:8]);
    send_byte(w[23:16]);
    send_byte(w[31:24]);
  endtask

  task automatic wait_done();
    for (int k = 0; k < 60 && !bus.ld_done_o; k++) @(negedge clk);
    chk("done_seen", {31'b0, bus.ld_done_o}, 32'd1);
    chk("hold_in_done", {31'b0, bus.core_hold_o}, 32'd1);
    @(negedge clk);
    chk("done_one_cycle", {31'b0, bus.ld_done_o}, 32'd0);
    chk("hold_released", {31'b0, bus.core_hold_o}, 32'd0);
  endtask

  task automatic load2(input logic [AW-1:0] b, input logic [31:0] w0, input logic [31:0] w1);
    start(b, 5'd2);
    send_word(w0);
    model[b] = w0;
    send_word(w1);
    model[(b + 1) % DEPTH] = w1;
    wait_done();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.im_addr_i  = 32'h0;
    bus.ld_start_i = 1'b0;
    bus.ld_base_i  = '0;
    bus.ld_count_i = '0;
    bus.ld_byte_i  = 8'h0;
    bus.ld_valid_i = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_data", bus.im_data_o, 32'h0);
    chk("rst_err", {31'b0, bus.addr_err_o}, 32'd0);
    chk("rst_perr", {31'b0, bus.parity_err_o}, 32'd0);
    chk("rst_hold", {31'b0, bus.core_hold_o}, 32'd0);
    chk("rst_ready", {31'b0, bus.ld_ready_o}, 32'd0);
    chk("rst_done", {31'b0, bus.ld_done_o}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    issue(32'h40, 1'b0);
    tick();

    // Two-word load from base 0, then back-to-back reads
    load2(4'd0, 32'h0000_0013, 32'h0010_0093);
    issue(32'h0, 1'b0);
    tick();
    issue(32'h4, 1'b0);
    tick();

    // Single word with valid gaps; reads during the session return NOP
    start(4'd2, 5'd1);
    chk("hold_after_start", {31'b0, bus.core_hold_o}, 32'd1);
    chk("ready_in_recv", {31'b0, bus.ld_ready_o}, 32'd1);
    issue(32'h8, 1'b1);
    tick();
    send_byte(8'hEF);
    @(negedge clk);
    send_byte(8'hBE);
    @(negedge clk);
    @(negedge clk);
    chk("no_done_in_gap", {31'b0, bus.ld_done_o}, 32'd0);
    send_byte(8'hAD);
    send_byte(8'hDE);
    model[2] = 32'hDEAD_BEEF;
    wait_done();
    issue(32'h8, 1'b0);
    tick();

    // Index wrap from the top entry; unmapped and unaligned addresses
    load2(4'd15, 32'hA5A5_0001, 32'h5A5A_0002);
    issue(32'h3C, 1'b0);
    tick();
    issue(32'h0, 1'b0);
    tick();
    issue(32'h40, 1'b0);
    tick();
    issue(32'h3D, 1'b0);
    tick();
    issue(32'hFFFF_FFFC, 1'b0);
    tick();

    // Zero-length session finishes immediately and writes nothing
    start(4'd0, 5'd0);
    chk("cnt0_done", {31'b0, bus.ld_done_o}, 32'd1);
    chk("cnt0_hold", {31'b0, bus.core_hold_o}, 32'd1);
    @(negedge clk);
    chk("cnt0_done_drop", {31'b0, bus.ld_done_o}, 32'd0);
    chk("cnt0_hold_drop", {31'b0, bus.core_hold_o}, 32'd0);
    issue(32'h0, 1'b0);
    tick();

    // A start pulse mid-session is ignored
    start(4'd5, 5'd1);
    send_byte(8'h11);
    send_byte(8'h22);
    bus.ld_start_i = 1'b1;
    bus.ld_base_i  = 4'd0;
    bus.ld_count_i = 5'd0;
    @(negedge clk);
    bus.ld_start_i = 1'b0;
    chk("restart_no_done", {31'b0, bus.ld_done_o}, 32'd0);
    chk("restart_still_recv", {31'b0, bus.ld_ready_o}, 32'd1);
    send_byte(8'h33);
    send_byte(8'h44);
    model[5] = 32'h4433_2211;
    wait_done();
    issue(32'h14, 1'b0);
    tick();
    issue(32'h0, 1'b0);
    tick();

    // Reset mid-session keeps completed words, drops the partial one
    start(4'd3, 5'd2);
    send_word(32'h0BAD_F00D);
    model[3] = 32'h0BAD_F00D;
    send_byte(8'h77);
    send_byte(8'h66);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_hold", {31'b0, bus.core_hold_o}, 32'd0);
    chk("midrst_ready", {31'b0, bus.ld_ready_o}, 32'd0);
    chk("midrst_data", bus.im_data_o, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    issue(32'hC, 1'b0);
    tick();
    start(4'd4, 5'd1);
    send_word(32'h1234_5678);
    model[4] = 32'h1234_5678;
    wait_done();
    issue(32'h10, 1'b0);
    tick();

`ifdef IMEM_PARITY_EN
    // Corrupt one stored data bit: data returned as stored, parity flagged
    dut.mem[1] = dut.mem[1] ^ 33'h1;
    bus.im_addr_i = 32'h4;
    push_exp(32'h4, model[1] ^ 32'h1, 1'b0, 1'b1);
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
